blit_cmd_queue: RTL and testbench

BLIT_CMD_QUEUE -- requirements
Module: blit_cmd_queue

---
 rtl/blit_cmd_queue_if.sv | 30 +++
 rtl/blit_cmd_queue.sv | 107 ++++++++++
 tb/tb_blit_cmd_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/blit_cmd_queue_if.sv
// Handshake and status bundle for the blit command queue.
// Producer/consumer logic uses the master side; the queue uses the slave side.
interface blit_cmd_queue_if #(
   parameter int unsigned WIDTH      = 96,
   parameter int unsigned DEPTH_LOG2 = 8
);
   logic [WIDTH-1:0]    cmd_in;
   logic                cmd_in_valid;
   logic [WIDTH-1:0]    cmd_out;
   logic                cmd_out_valid;
   logic                next_cmd;
   logic                flush;
   logic [DEPTH_LOG2:0] fifo_slots_free;
   logic                fifo_almost_full;
   logic                fifo_overflow;
   logic                fifo_underflow;
   logic                err_clear;

   modport master (
      output cmd_in, cmd_in_valid, next_cmd, flush, err_clear,
      input  cmd_out, cmd_out_valid, fifo_slots_free, fifo_almost_full,
             fifo_overflow, fifo_underflow
   );

   modport slave (
      input  cmd_in, cmd_in_valid, next_cmd, flush, err_clear,
      output cmd_out, cmd_out_valid, fifo_slots_free, fifo_almost_full,
             fifo_overflow, fifo_underflow
   );
endinterface

// File: rtl/blit_cmd_queue.sv
// Command FIFO with a registered head word, bypass on push-to-empty,
// free-slot/almost-full status and sticky overflow/underflow flags.
module blit_cmd_queue #(
   parameter int unsigned WIDTH      = 96,
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned AF_SLOTS   = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   blit_cmd_queue_if.slave q_io
);
   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
   localparam logic [PtrW-1:0] DepthVal = PtrW'(Depth);
   localparam logic [PtrW-1:0] AfVal    = PtrW'(AF_SLOTS);
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

   logic [WIDTH-1:0] mem [Depth];

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] cmd_out_q, cmd_out_d;
   logic             valid_q, valid_d;
   logic [PtrW-1:0]  free_q, free_d;
   logic             af_q, af_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [PtrW-1:0]  level, level_d;
   logic             full, pop_acc, push_acc;

   always_comb begin
      level    = wr_ptr_q - rd_ptr_q;
      full     = (level == DepthVal);
      pop_acc  = q_io.next_cmd && valid_q;
      push_acc = q_io.cmd_in_valid && (!full || pop_acc);

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cmd_out_d = cmd_out_q;
      valid_d   = valid_q;

      if (q_io.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         valid_d  = 1'b0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PtrOne;
         if (pop_acc)  rd_ptr_d = rd_ptr_q + PtrOne;
         // Reload the head only when it is consumed or absent; the new head may be
         // the word written this very cycle, which is not in the RAM yet.
         if (pop_acc || !valid_q) begin
            valid_d = (wr_ptr_d != rd_ptr_d);
            if (push_acc && (rd_ptr_d[DEPTH_LOG2-1:0] == wr_ptr_q[DEPTH_LOG2-1:0])) begin
               cmd_out_d = q_io.cmd_in;
            end else begin
               cmd_out_d = mem[rd_ptr_d[DEPTH_LOG2-1:0]];
            end
         end
      end

      level_d = wr_ptr_d - rd_ptr_d;
      free_d  = DepthVal - level_d;
      af_d    = (free_d <= AfVal);

      // Set wins over clear; flush suppresses both set conditions.
      ovf_d = (q_io.cmd_in_valid && !push_acc && !q_io.flush) ||
              (ovf_q && !q_io.err_clear);
      unf_d = (q_io.next_cmd && !valid_q && !q_io.flush) ||
              (unf_q && !q_io.err_clear);
   end

   always_ff @(posedge clk_i) begin
      if (push_acc && !q_io.flush) begin
         mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= q_io.cmd_in;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cmd_out_q <= '0;
         valid_q   <= 1'b0;
         free_q    <= DepthVal;
         af_q      <= (DepthVal <= AfVal);
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cmd_out_q <= cmd_out_d;
         valid_q   <= valid_d;
         free_q    <= free_d;
         af_q      <= af_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign q_io.cmd_out          = cmd_out_q;
   assign q_io.cmd_out_valid    = valid_q;
   assign q_io.fifo_slots_free  = free_q;
   assign q_io.fifo_almost_full = af_q;
   assign q_io.fifo_overflow    = ovf_q;
   assign q_io.fifo_underflow   = unf_q;
endmodule

// File: tb/tb_blit_cmd_queue.sv
// Directed bench for blit_cmd_queue with WIDTH=8, DEPTH_LOG2=2, AF_SLOTS=1.
module tb_blit_cmd_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   blit_cmd_queue_if #(.WIDTH(8), .DEPTH_LOG2(2)) bus ();

   blit_cmd_queue #(.WIDTH(8), .DEPTH_LOG2(2), .AF_SLOTS(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .q_io  (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.cmd_in_valid = 1'b0;
      bus.next_cmd     = 1'b0;
      bus.flush        = 1'b0;
      bus.err_clear    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cmd_in = 8'h00;
      idle();
      #12;
      total++; if (bus.cmd_out_valid !== 1'b0) begin bad++;
         $display("FAIL reset valid: got %b want 0", bus.cmd_out_valid); end
      total++; if (bus.fifo_slots_free !== 3'd4) begin bad++;
         $display("FAIL reset slots: got %0d want 4", bus.fifo_slots_free); end
      total++; if (bus.fifo_almost_full !== 1'b0) begin bad++;
         $display("FAIL reset af: got %b want 0", bus.fifo_almost_full); end
      total++; if ({bus.fifo_overflow, bus.fifo_underflow} !== 2'b00) begin bad++;
         $display("FAIL reset flags: got %b%b want 00", bus.fifo_overflow, bus.fifo_underflow); end
      total++; if (bus.cmd_out !== 8'h00) begin bad++;
         $display("FAIL reset data: got %h want 00", bus.cmd_out); end
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [2:0] exp_slots;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_in = vals[i]; bus.cmd_in_valid = 1'b1;
         step();
         exp_slots = 3'(3 - i);
         total++; if (bus.fifo_slots_free !== exp_slots) begin bad++;
            $display("FAIL fill slots[%0d]: got %0d want %0d", i, bus.fifo_slots_free, exp_slots); end
         total++; if (bus.fifo_almost_full !== (exp_slots <= 3'd1)) begin bad++;
            $display("FAIL fill af[%0d]: got %b want %b", i, bus.fifo_almost_full, exp_slots <= 3'd1); end
         total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== 8'h11) begin bad++;
            $display("FAIL fill head[%0d]: got %b/%h want 1/11", i, bus.cmd_out_valid, bus.cmd_out); end
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.cmd_out !== vals[i]) begin bad++;
            $display("FAIL drain data[%0d]: got %h want %h", i, bus.cmd_out, vals[i]); end
         bus.next_cmd = 1'b1;
         step();
         total++; if (bus.fifo_slots_free !== 3'(i + 1) || bus.cmd_out_valid !== (i < 3)) begin bad++;
            $display("FAIL drain state[%0d]: got %0d/%b want %0d/%b", i, bus.fifo_slots_free,
                     bus.cmd_out_valid, i + 1, i < 3); end
      end
      idle();
      total++; if (bus.fifo_overflow !== 1'b0) begin bad++;
         $display("FAIL fill ovf: got %b want 0", bus.fifo_overflow); end
   endtask

   task automatic test_full_boundary();
      logic [7:0] outs [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
      for (int i = 0; i < 4; i++) begin
         bus.cmd_in = 8'(8'h11 * (i + 1)); bus.cmd_in_valid = 1'b1;
         step();
      end
      bus.cmd_in = 8'h55;
      step();
      total++; if (bus.fifo_overflow !== 1'b1 || bus.fifo_slots_free !== 3'd0) begin bad++;
         $display("FAIL full push: got ovf=%b slots=%0d want 1/0", bus.fifo_overflow, bus.fifo_slots_free); end
      bus.cmd_in = 8'h66; bus.next_cmd = 1'b1;
      step();
      total++; if (bus.fifo_slots_free !== 3'd0 || bus.cmd_out !== 8'h22) begin bad++;
         $display("FAIL full pushpop: got slots=%0d head=%h want 0/22", bus.fifo_slots_free, bus.cmd_out); end
      idle();
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== outs[i]) begin bad++;
            $display("FAIL full drain[%0d]: got %b/%h want 1/%h", i, bus.cmd_out_valid, bus.cmd_out, outs[i]); end
         bus.next_cmd = 1'b1;
         step();
      end
      idle();
      total++; if (bus.cmd_out_valid !== 1'b0 || bus.fifo_slots_free !== 3'd4) begin bad++;
         $display("FAIL full empty: got %b/%0d want 0/4", bus.cmd_out_valid, bus.fifo_slots_free); end
      bus.err_clear = 1'b1;
      step();
      idle();
      total++; if (bus.fifo_overflow !== 1'b0) begin bad++;
         $display("FAIL ovf clear: got %b want 0", bus.fifo_overflow); end
   endtask

   task automatic test_bypass_throughput();
      logic [7:0] exp_v;
      bus.cmd_in = 8'hA5; bus.cmd_in_valid = 1'b1;
      step();
      total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== 8'hA5 || bus.fifo_slots_free !== 3'd3) begin
         bad++; $display("FAIL bypass: got %b/%h/%0d want 1/a5/3", bus.cmd_out_valid, bus.cmd_out,
                         bus.fifo_slots_free); end
      for (int k = 0; k < 10; k++) begin
         exp_v = 8'(8'hB0 + k);
         bus.cmd_in = exp_v; bus.cmd_in_valid = 1'b1; bus.next_cmd = 1'b1;
         step();
         total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== exp_v || bus.fifo_slots_free !== 3'd3) begin
            bad++; $display("FAIL stream[%0d]: got %b/%h/%0d want 1/%h/3", k, bus.cmd_out_valid,
                            bus.cmd_out, bus.fifo_slots_free, exp_v); end
      end
      bus.cmd_in_valid = 1'b0;
      step();
      idle();
      total++; if (bus.cmd_out_valid !== 1'b0 || bus.fifo_slots_free !== 3'd4) begin bad++;
         $display("FAIL stream end: got %b/%0d want 0/4", bus.cmd_out_valid, bus.fifo_slots_free); end
   endtask

   task automatic test_underflow_clear();
      bus.next_cmd = 1'b1;
      step();
      total++; if (bus.fifo_underflow !== 1'b1 || bus.fifo_slots_free !== 3'd4) begin bad++;
         $display("FAIL underflow: got %b/%0d want 1/4", bus.fifo_underflow, bus.fifo_slots_free); end
      bus.err_clear = 1'b1;
      step();
      total++; if (bus.fifo_underflow !== 1'b1) begin bad++;
         $display("FAIL unf set wins: got %b want 1", bus.fifo_underflow); end
      bus.next_cmd = 1'b0;
      step();
      idle();
      total++; if (bus.fifo_underflow !== 1'b0) begin bad++;
         $display("FAIL unf clear: got %b want 0", bus.fifo_underflow); end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 3; i++) begin
         bus.cmd_in = 8'(i); bus.cmd_in_valid = 1'b1;
         step();
      end
      bus.cmd_in = 8'h77; bus.flush = 1'b1;
      step();
      total++; if (bus.fifo_slots_free !== 3'd4 || bus.cmd_out_valid !== 1'b0 || bus.fifo_overflow !== 1'b0)
         begin bad++; $display("FAIL flush: got %0d/%b/%b want 4/0/0", bus.fifo_slots_free,
                               bus.cmd_out_valid, bus.fifo_overflow); end
      bus.cmd_in_valid = 1'b0; bus.next_cmd = 1'b1;
      step();
      total++; if (bus.fifo_underflow !== 1'b0) begin bad++;
         $display("FAIL flush pop: got unf=%b want 0", bus.fifo_underflow); end
      idle();
      bus.cmd_in = 8'h88; bus.cmd_in_valid = 1'b1;
      step();
      idle();
      total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== 8'h88) begin bad++;
         $display("FAIL post flush: got %b/%h want 1/88", bus.cmd_out_valid, bus.cmd_out); end
   endtask

   task automatic test_async_reset();
      bus.cmd_in = 8'h99; bus.cmd_in_valid = 1'b1;
      step();
      idle();
      total++; if (bus.fifo_slots_free !== 3'd2) begin bad++;
         $display("FAIL pre reset slots: got %0d want 2", bus.fifo_slots_free); end
      #2 rst = 1'b1;
      #1;
      total++; if (bus.cmd_out_valid !== 1'b0 || bus.cmd_out !== 8'h00 || bus.fifo_slots_free !== 3'd4 ||
                   bus.fifo_almost_full !== 1'b0) begin bad++;
         $display("FAIL async reset: got %b/%h/%0d/%b want 0/00/4/0", bus.cmd_out_valid, bus.cmd_out,
                  bus.fifo_slots_free, bus.fifo_almost_full); end
      #1 rst = 1'b0;
      bus.cmd_in = 8'hC3; bus.cmd_in_valid = 1'b1;
      step();
      idle();
      total++; if (bus.cmd_out_valid !== 1'b1 || bus.cmd_out !== 8'hC3 || bus.fifo_slots_free !== 3'd3) begin
         bad++; $display("FAIL after reset: got %b/%h/%0d want 1/c3/3", bus.cmd_out_valid, bus.cmd_out,
                         bus.fifo_slots_free); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_boundary();
      test_bypass_throughput();
      test_underflow_clear();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
